prepare_log_ring: RTL and testbench
===================================

// Module: prepare_log_ring
// PURPOSE
//  Parametrised successor log-append engine for the VR replica path: ingests a prepare
//  (op number, declared flit length, payload flits), writes payload into circular log data
//  memory and one header into circular header memory, then reports ok/drop. Adds in-order
//  op checking, wrap-around, length-mismatch discard and commit-driven reclaim.
// PARAMETERS
//  DATA_W      512   payload flit width (bits)
//  OPNUM_W     64    VR op-number width
//  HDR_DEPTH   64    header slots; power of 2, >=2
//  DATA_DEPTH  1024  data flits; power of 2, >=HDR_DEPTH
//  LEN_W       $clog2(DATA_DEPTH)+1  declared-length width; derived
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        one clock; reset is synchronous and active-low
//  req_val/rdy   in/out 1      prepare metadata handshake
//  req_op_num    in   OPNUM_W  op number of this prepare
//  req_len       in   LEN_W    declared payload length, flits (>=1)
//  data_val/rdy  in/out 1      payload flit handshake
//  data          in   DATA_W   payload flit
//  data_last     in   1        final flit of payload
//  result_val/rdy out/in 1     completion handshake
//  result_ok     out  1        1=logged, 0=dropped
//  hdr_wr_val/rdy out/in 1     header memory write handshake
//  hdr_wr_addr   out  $clog2(HDR_DEPTH)   header slot
//  hdr_wr_data   out  OPNUM_W+2*LEN_W    {op, start flit addr zero-ext, len}
//  data_wr_val/rdy out/in 1    data memory write handshake
//  data_wr_addr  out  $clog2(DATA_DEPTH)  flit address
//  data_wr_data  out  DATA_W   flit (= data, passthrough)
//  reclaim_val/rdy in/out 1    commit notification handshake
//  reclaim_op    in   OPNUM_W  highest committed op; entries <= it are freed
//  last_op       out  OPNUM_W  op of newest logged entry
//  used_entries  out  $clog2(HDR_DEPTH)+1; used_flits out LEN_W  occupancy
// BEHAVIOUR
//  Reset (rst_n=0 at edge): all *_val=0, result_ok=0, last_op=0, pointers/counts=0,
//   state IDLE, reclaim FSM R_IDLE; any in-flight entry abandoned, memories untouched.
//  Append FSM: IDLE -> CHECK -> {WR_DATA|DRAIN} -> WR_HDR(ok only) -> RESULT -> IDLE.
//  IDLE: req_rdy=1; on req_val latch op,len; start=data_tail.
//  CHECK (1 cycle): ok iff op==last_op+1 (wraps mod 2^OPNUM_W) && used_entries<HDR_DEPTH
//   && DATA_DEPTH-used_flits>=len && len!=0; else DRAIN.
//  WR_DATA: data_rdy=data_wr_rdy; data_wr_val=data_val; addr=start+cnt mod DATA_DEPTH
//   (entries may span wrap). Each beat cnt++. Mismatch = last with cnt+1!=len, or cnt+1==len
//   without last: mark bad, continue to DRAIN until last (no further writes).
//  DRAIN: data_rdy=1, no memory writes, exits after last beat.
//  WR_HDR: hdr_wr_val=1 at hdr_tail until hdr_wr_rdy; then hdr_tail++, data_tail+=len,
//   counts += (1,len), last_op=op, internal len[hdr_tail]=len. Bad/drop: nothing advances.
//  RESULT: result_val=1 until result_rdy; minimum latency last flit -> result_val = 2 cycles.
//  Reclaim FSM: R_IDLE reclaim_rdy=1; n = min(reclaim_op-oldest_op+1, used_entries),
//   0 if reclaim_op<oldest_op; R_FREE frees one entry/cycle: head++, used_entries--,
//   used_flits-=len[head], oldest_op++. reclaim_rdy=0 while freeing.
//  Simultaneous append commit and free in same cycle: counters apply net delta.
//  Space check sees only stale-high occupancy (reclaim only frees), so never overcommits.
//  Full: header full or insufficient flits -> drop, result_ok=0, payload drained.
//  Empty: reclaim with used_entries=0 is a no-op, rdy returns next cycle.
// TESTING
//  Reset, op1 len4 -> 4 data writes addr0..3, hdr {1,0,4} addr0, result_ok=1, used=1/4.
//  op3 after op1 (gap) -> no writes, 3 flits drained, result_ok=0, last_op=1.
//  DATA_DEPTH=16: fill 14 flits, op len4 -> drop; reclaim op -> used=0; retry -> addrs 14,15,0,1.
//  HDR_DEPTH=4: 4 entries then 5th -> drop; reclaim_op=2 frees 2 in 2 cycles; 5th logs slot0.
//  op len3 with last on flit2 -> ok=0, tail unchanged; next op reuses same start addr.
//  Reclaim during WR_DATA with hdr_wr_rdy/data_wr_rdy random backpressure -> counts exact.

Source files
------------

// File: rtl/prepare_log_ring_if.sv
// Handshake and memory-port bundle for the prepare log-append engine.
// master = prepare source / memories / commit path, slave = prepare_log_ring.
interface prepare_log_ring_if #(
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned OPNUM_W    = 64,
    parameter int unsigned HDR_DEPTH  = 64,
    parameter int unsigned DATA_DEPTH = 1024
);
    localparam int unsigned LEN_W   = $clog2(DATA_DEPTH) + 1;
    localparam int unsigned HDR_AW  = $clog2(HDR_DEPTH);
    localparam int unsigned DATA_AW = $clog2(DATA_DEPTH);

    logic                        req_val;
    logic                        req_rdy;
    logic [OPNUM_W-1:0]          req_op_num;
    logic [LEN_W-1:0]            req_len;

    logic                        data_val;
    logic                        data_rdy;
    logic [DATA_W-1:0]           data;
    logic                        data_last;

    logic                        result_val;
    logic                        result_rdy;
    logic                        result_ok;

    logic                        hdr_wr_val;
    logic                        hdr_wr_rdy;
    logic [HDR_AW-1:0]           hdr_wr_addr;
    logic [OPNUM_W+2*LEN_W-1:0]  hdr_wr_data;

    logic                        data_wr_val;
    logic                        data_wr_rdy;
    logic [DATA_AW-1:0]          data_wr_addr;
    logic [DATA_W-1:0]           data_wr_data;

    logic                        reclaim_val;
    logic                        reclaim_rdy;
    logic [OPNUM_W-1:0]          reclaim_op;

    logic [OPNUM_W-1:0]          last_op;
    logic [HDR_AW:0]             used_entries;
    logic [LEN_W-1:0]            used_flits;

    modport master (
        output req_val, req_op_num, req_len,
        input  req_rdy,
        output data_val, data, data_last,
        input  data_rdy,
        input  result_val, result_ok,
        output result_rdy,
        input  hdr_wr_val, hdr_wr_addr, hdr_wr_data,
        output hdr_wr_rdy,
        input  data_wr_val, data_wr_addr, data_wr_data,
        output data_wr_rdy,
        output reclaim_val, reclaim_op,
        input  reclaim_rdy,
        input  last_op, used_entries, used_flits
    );

    modport slave (
        input  req_val, req_op_num, req_len,
        output req_rdy,
        input  data_val, data, data_last,
        output data_rdy,
        output result_val, result_ok,
        input  result_rdy,
        output hdr_wr_val, hdr_wr_addr, hdr_wr_data,
        input  hdr_wr_rdy,
        output data_wr_val, data_wr_addr, data_wr_data,
        input  data_wr_rdy,
        input  reclaim_val, reclaim_op,
        output reclaim_rdy,
        output last_op, used_entries, used_flits
    );
endinterface

// File: rtl/prepare_log_ring.sv
// Circular log-append engine: in-order prepare check, payload/header writes with wrap,
// length-mismatch discard, and commit-driven reclaim running alongside appends.
module prepare_log_ring #(
    parameter int unsigned DATA_W     = 512,
    parameter int unsigned OPNUM_W    = 64,
    parameter int unsigned HDR_DEPTH  = 64,
    parameter int unsigned DATA_DEPTH = 1024
) (
    input logic                clk,
    input logic                rst_n,
    prepare_log_ring_if.slave  bus
);
    localparam int unsigned LEN_W   = $clog2(DATA_DEPTH) + 1;
    localparam int unsigned HDR_AW  = $clog2(HDR_DEPTH);
    localparam int unsigned DATA_AW = $clog2(DATA_DEPTH);
    localparam logic [HDR_AW:0]  HDR_CAP  = HDR_DEPTH[HDR_AW:0];
    localparam logic [LEN_W-1:0] DATA_CAP = DATA_DEPTH[LEN_W-1:0];

    typedef enum logic [2:0] {IDLE, CHECK, WR_DATA, DRAIN, WR_HDR, RESULT} state_t;
    typedef enum logic {R_IDLE, R_FREE} rstate_t;

    state_t  state, state_nxt;
    rstate_t rstate, rstate_nxt;

    logic [OPNUM_W-1:0] op_q, last_op_q;
    logic [LEN_W-1:0]   len_q, cnt_q, used_flits_q;
    logic [DATA_AW-1:0] start_q, data_tail;
    logic [HDR_AW-1:0]  hdr_tail, hdr_head;
    logic [HDR_AW:0]    used_entries_q, rem_q;
    logic               bad_q;
    logic [LEN_W-1:0]   len_mem [HDR_DEPTH];

    logic               check_ok, at_len, beat, beat_mismatch, hdr_fire, free_fire;
    logic [OPNUM_W-1:0] oldest_op, reclaim_span;
    logic [OPNUM_W:0]   span_p1;
    logic [HDR_AW:0]    reclaim_n;
    logic [LEN_W-1:0]   free_len;

    assign free_len = len_mem[hdr_head];

    always_comb begin
        check_ok = (op_q == last_op_q + OPNUM_W'(1))
                && (used_entries_q < HDR_CAP)
                && ((DATA_CAP - used_flits_q) >= len_q)
                && (len_q != '0);
        at_len        = (cnt_q + LEN_W'(1)) == len_q;
        beat          = (state == WR_DATA) && bus.data_val && bus.data_wr_rdy;
        beat_mismatch = beat && (bus.data_last != at_len);
        hdr_fire      = (state == WR_HDR) && bus.hdr_wr_rdy;
        free_fire     = (rstate == R_FREE);

        // Live entries always hold consecutive ops, so the oldest is derived, not stored.
        oldest_op    = last_op_q - OPNUM_W'(used_entries_q) + OPNUM_W'(1);
        reclaim_span = bus.reclaim_op - oldest_op;
        span_p1      = {1'b0, reclaim_span} + (OPNUM_W+1)'(1);
        if (used_entries_q == '0 || bus.reclaim_op < oldest_op)
            reclaim_n = '0;
        else if (span_p1 < (OPNUM_W+1)'(used_entries_q))
            reclaim_n = (HDR_AW+1)'(span_p1);
        else
            reclaim_n = used_entries_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            rstate         <= R_IDLE;
            op_q           <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            start_q        <= '0;
            bad_q          <= 1'b0;
            last_op_q      <= '0;
            data_tail      <= '0;
            hdr_tail       <= '0;
            hdr_head       <= '0;
            used_entries_q <= '0;
            used_flits_q   <= '0;
            rem_q          <= '0;
        end else begin
            state  <= state_nxt;
            rstate <= rstate_nxt;
            if (state == IDLE && bus.req_val) begin
                op_q    <= bus.req_op_num;
                len_q   <= bus.req_len;
                start_q <= data_tail;
                cnt_q   <= '0;
                bad_q   <= 1'b0;
            end
            if (state == CHECK && !check_ok)
                bad_q <= 1'b1;
            if (beat) begin
                cnt_q <= cnt_q + LEN_W'(1);
                if (beat_mismatch)
                    bad_q <= 1'b1;
            end
            if (hdr_fire) begin
                hdr_tail  <= hdr_tail + HDR_AW'(1);
                data_tail <= data_tail + len_q[DATA_AW-1:0];
                last_op_q <= op_q;
            end
            if (free_fire)
                hdr_head <= hdr_head + HDR_AW'(1);
            if (rstate == R_IDLE && bus.reclaim_val)
                rem_q <= reclaim_n;
            else if (free_fire)
                rem_q <= rem_q - (HDR_AW+1)'(1);
            // Append and free may land in the same cycle; apply both as one net delta.
            used_entries_q <= used_entries_q + (HDR_AW+1)'(hdr_fire) - (HDR_AW+1)'(free_fire);
            used_flits_q   <= used_flits_q + (hdr_fire ? len_q : '0) - (free_fire ? free_len : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && hdr_fire)
            len_mem[hdr_tail] <= len_q;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.req_val) state_nxt = CHECK;
            CHECK:   state_nxt = check_ok ? WR_DATA : DRAIN;
            WR_DATA: begin
                if (beat) begin
                    if (beat_mismatch)
                        state_nxt = bus.data_last ? RESULT : DRAIN;
                    else if (bus.data_last)
                        state_nxt = WR_HDR;
                end
            end
            DRAIN:   if (bus.data_val && bus.data_last) state_nxt = RESULT;
            WR_HDR:  if (bus.hdr_wr_rdy) state_nxt = RESULT;
            RESULT:  if (bus.result_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        rstate_nxt = rstate;
        unique case (rstate)
            R_IDLE:  if (bus.reclaim_val && reclaim_n != '0) rstate_nxt = R_FREE;
            R_FREE:  if (rem_q == (HDR_AW+1)'(1)) rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        bus.req_rdy      = (state == IDLE);
        bus.data_rdy     = (state == WR_DATA) ? bus.data_wr_rdy : (state == DRAIN);
        bus.data_wr_val  = (state == WR_DATA) && bus.data_val;
        bus.data_wr_addr = start_q + cnt_q[DATA_AW-1:0];
        bus.data_wr_data = bus.data;
        bus.hdr_wr_val   = (state == WR_HDR);
        bus.hdr_wr_addr  = hdr_tail;
        bus.hdr_wr_data  = {op_q, {1'b0, start_q}, len_q};
        bus.result_val   = (state == RESULT);
        bus.result_ok    = (state == RESULT) && !bad_q;
        bus.reclaim_rdy  = (rstate == R_IDLE);
        bus.last_op      = last_op_q;
        bus.used_entries = used_entries_q;
        bus.used_flits   = used_flits_q;
    end
endmodule

// File: tb/tb_prepare_log_ring.sv
// Directed + randomized bench for prepare_log_ring against a queue-based log model.
module tb_prepare_log_ring;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OPNUM_W    = 16;
    localparam int unsigned HDR_DEPTH  = 4;
    localparam int unsigned DATA_DEPTH = 16;
    localparam int unsigned LEN_W      = $clog2(DATA_DEPTH) + 1;
    localparam int unsigned HW         = OPNUM_W + 2*LEN_W;
    localparam int unsigned LIMIT      = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bp_en = 1'b0;

    prepare_log_ring_if #(.DATA_W(DATA_W), .OPNUM_W(OPNUM_W), .HDR_DEPTH(HDR_DEPTH),
                          .DATA_DEPTH(DATA_DEPTH)) bus ();
    prepare_log_ring #(.DATA_W(DATA_W), .OPNUM_W(OPNUM_W), .HDR_DEPTH(HDR_DEPTH),
                       .DATA_DEPTH(DATA_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        res_ok_s;

    logic [31:0]        mw_addr[$];
    logic [DATA_W-1:0]  mw_data[$];
    logic [31:0]        mh_addr[$];
    logic [HW-1:0]      mh_data[$];
    logic [DATA_W-1:0]  sent_q[$];

    // Reference log: live entries oldest first, plus write cursors.
    logic [OPNUM_W-1:0] m_ops[$];
    int unsigned        m_lens[$];
    logic [OPNUM_W-1:0] m_last;
    int unsigned        m_tail, m_htail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor sampled one time unit before the active edge.
    always @(negedge clk) begin
        #4;
        if (bus.data_wr_val && bus.data_wr_rdy) begin
            mw_addr.push_back(32'(bus.data_wr_addr));
            mw_data.push_back(bus.data_wr_data);
        end
        if (bus.hdr_wr_val && bus.hdr_wr_rdy) begin
            mh_addr.push_back(32'(bus.hdr_wr_addr));
            mh_data.push_back(bus.hdr_wr_data);
        end
    end

    initial begin
        bus.data_wr_rdy = 1'b1;
        bus.hdr_wr_rdy  = 1'b1;
        forever begin
            @(negedge clk);
            bus.data_wr_rdy = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.hdr_wr_rdy  = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    function automatic logic rdy_of(input int unsigned w);
        case (w)
            0:       return bus.req_rdy;
            1:       return bus.data_rdy;
            2:       return bus.reclaim_rdy;
            default: return bus.result_val;
        endcase
    endfunction

    task automatic wait_hs(input int unsigned w, input string tag);
        int unsigned t = 0;
        logic f;
        forever begin
            #4;
            f = rdy_of(w);
            if (f && w == 3) res_ok_s = bus.result_ok;
            @(negedge clk);
            if (f) break;
            t++;
            if (t > LIMIT) begin
                n_cmp++; n_bad++;
                $error("FAIL %s_timeout: observed=no handshake expected=handshake within %0d cycles", tag, LIMIT);
                break;
            end
        end
    endtask

    task automatic send_prepare(input logic [OPNUM_W-1:0] op, input logic [LEN_W-1:0] len,
                                input int unsigned nflits, input bit gaps);
        sent_q.delete();
        bus.req_val = 1'b1; bus.req_op_num = op; bus.req_len = len;
        wait_hs(0, "req");
        bus.req_val = 1'b0;
        for (int i = 0; i < int'(nflits); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
            bus.data_val  = 1'b1;
            bus.data      = DATA_W'($urandom);
            bus.data_last = (i == int'(nflits) - 1);
            sent_q.push_back(bus.data);
            wait_hs(1, "data");
            bus.data_val  = 1'b0;
            bus.data_last = 1'b0;
        end
        wait_hs(3, "result");
    endtask

    function automatic int unsigned m_flits();
        int unsigned s = 0;
        foreach (m_lens[i]) s += m_lens[i];
        return s;
    endfunction

    task automatic check_prepare(input logic [OPNUM_W-1:0] op, input logic [LEN_W-1:0] len,
                                 input int unsigned nflits);
        bit accept, exp_ok;
        int unsigned nwr;
        logic [HW-1:0] exp_h;
        accept = (op == OPNUM_W'(m_last + 1)) && (m_ops.size() < HDR_DEPTH)
              && (DATA_DEPTH - m_flits() >= 32'(len)) && (len != 0);
        exp_ok = accept && (nflits == 32'(len));
        nwr    = !accept ? 0 : (nflits < 32'(len) ? nflits : 32'(len));
        chk("result_ok", 64'(res_ok_s), 64'(exp_ok));
        chk("n_data_wr", 64'(mw_addr.size()), 64'(nwr));
        for (int i = 0; i < int'(nwr) && i < mw_addr.size(); i++) begin
            chk("data_wr_addr", 64'(mw_addr[i]), 64'((m_tail + 32'(i)) % DATA_DEPTH));
            chk("data_wr_data", 64'(mw_data[i]), 64'(sent_q[i]));
        end
        chk("n_hdr_wr", 64'(mh_addr.size()), 64'(exp_ok));
        if (exp_ok && mh_addr.size() > 0) begin
            exp_h = {op, LEN_W'(m_tail), len};
            chk("hdr_wr_addr", 64'(mh_addr[0]), 64'(m_htail));
            chk("hdr_wr_data", 64'(mh_data[0]), 64'(exp_h));
        end
        if (exp_ok) begin
            m_ops.push_back(op);
            m_lens.push_back(32'(len));
            m_tail  = (m_tail + 32'(len)) % DATA_DEPTH;
            m_htail = (m_htail + 1) % HDR_DEPTH;
            m_last  = op;
        end
        mw_addr.delete(); mw_data.delete(); mh_addr.delete(); mh_data.delete();
    endtask

    task automatic do_reclaim(input logic [OPNUM_W-1:0] rop, output int unsigned cyc);
        logic f;
        bus.reclaim_val = 1'b1; bus.reclaim_op = rop;
        wait_hs(2, "reclaim");
        bus.reclaim_val = 1'b0;
        cyc = 0;
        forever begin
            #4; f = bus.reclaim_rdy;
            @(negedge clk);
            if (f) break;
            cyc++;
            if (cyc > LIMIT) begin
                n_cmp++; n_bad++;
                $error("FAIL reclaim_busy_timeout: observed=rdy low expected=rdy within %0d cycles", LIMIT);
                break;
            end
        end
    endtask

    task automatic model_reclaim(input logic [OPNUM_W-1:0] rop, input int unsigned cyc);
        int unsigned n = 0;
        while (m_ops.size() > 0 && m_ops[0] <= rop) begin
            void'(m_ops.pop_front());
            void'(m_lens.pop_front());
            n++;
        end
        chk("free_cycles", 64'(cyc), 64'(n));
    endtask

    task automatic check_occ();
        chk("last_op", 64'(bus.last_op), 64'(m_last));
        chk("used_entries", 64'(bus.used_entries), 64'(m_ops.size()));
        chk("used_flits", 64'(bus.used_flits), 64'(m_flits()));
    endtask

    task automatic model_reset();
        m_ops.delete(); m_lens.delete();
        m_last = '0; m_tail = 0; m_htail = 0;
        mw_addr.delete(); mw_data.delete(); mh_addr.delete(); mh_data.delete();
    endtask

    task automatic check_reset_state();
        chk("rst_req_rdy", 64'(bus.req_rdy), 64'(1));
        chk("rst_result_val", 64'(bus.result_val), 64'(0));
        chk("rst_result_ok", 64'(bus.result_ok), 64'(0));
        chk("rst_hdr_wr_val", 64'(bus.hdr_wr_val), 64'(0));
        chk("rst_data_wr_val", 64'(bus.data_wr_val), 64'(0));
        chk("rst_reclaim_rdy", 64'(bus.reclaim_rdy), 64'(1));
        check_occ();
    endtask

    // Send a prepare, then compare writes, result and occupancy with the model.
    task automatic step(input int unsigned op, input int unsigned len, input int unsigned nflits);
        send_prepare(OPNUM_W'(op), LEN_W'(len), nflits, 1'b0);
        check_prepare(OPNUM_W'(op), LEN_W'(len), nflits);
        check_occ();
    endtask

    task automatic reclaim_step(input int unsigned rop);
        int unsigned cyc;
        do_reclaim(OPNUM_W'(rop), cyc);
        model_reclaim(OPNUM_W'(rop), cyc);
        check_occ();
    endtask

    initial begin
        logic [OPNUM_W-1:0] rop, op;
        int unsigned len, dly, cyc;
        bus.req_val = 1'b0; bus.req_op_num = '0; bus.req_len = '0;
        bus.data_val = 1'b0; bus.data = '0; bus.data_last = 1'b0;
        bus.result_rdy = 1'b1;
        bus.reclaim_val = 1'b0; bus.reclaim_op = '0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset_state();

        step(1, 4, 4);              // writes 0..3, header {1,0,4} in slot 0
        step(3, 3, 3);              // op gap: drained, dropped
        step(2, 4, 4);
        step(3, 6, 6);              // 14 of 16 flits used
        step(4, 4, 4);              // insufficient flits: dropped
        reclaim_step(3);            // three entries freed
        step(4, 4, 4);              // wraps: 14,15,0,1
        step(5, 1, 1);
        step(6, 1, 1);
        step(7, 1, 1);              // header ring full
        step(8, 1, 1);              // dropped on header space
        reclaim_step(5);            // frees op4, op5
        reclaim_step(3);            // below oldest: no-op
        step(8, 1, 1);
        step(9, 3, 2);              // early last
        step(9, 3, 3);              // same start as the discarded attempt
        step(10, 2, 4);             // late last
        reclaim_step(9);
        reclaim_step(9);            // empty log
        step(10, 0, 1);             // zero length dropped
        step(10, 2, 2);

        bp_en = 1'b1;
        for (int r = 0; r < 12; r++) begin
            len = $urandom_range(1, 3);
            rop = m_last;
            op  = m_last + OPNUM_W'(1);
            dly = $urandom_range(0, 5);
            fork
                send_prepare(op, LEN_W'(len), len, 1'b1);
                begin
                    repeat (dly) @(negedge clk);
                    do_reclaim(rop, cyc);
                end
            join
            check_prepare(op, LEN_W'(len), len);
            model_reclaim(rop, cyc);
            check_occ();
        end
        bp_en = 1'b0;
        @(negedge clk);

        // Reset with a prepare in flight abandons it and clears all occupancy.
        bus.req_val = 1'b1; bus.req_op_num = m_last + OPNUM_W'(1); bus.req_len = LEN_W'(2);
        wait_hs(0, "req_abandon");
        bus.req_val = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_reset_state();
        step(1, 2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
